// File: rtl/u8layer_seq_pkg.sv
// u8layer_seq_pkg: shared types, constants and FSM encoding for the u8 layer sequencer
package u8layer_seq_pkg;
  typedef logic [7:0] u8_t;
  typedef logic [10:0] u11_t;
  typedef logic [19:0] u20_t;
  typedef logic [31:0] u32_t;
  localparam int ADRGEN_NPARAM = 23;
  localparam int ADRGEN_LANE_BASE = 24;
  localparam int DSC_STRIDE = 32;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LANE, S_NORM, S_LWR, S_KICK, S_WAIT_RUN, S_WAIT_DONE, S_NEXT, S_DONE
  } state_t;
  function automatic u32_t lane_word(input u11_t y, input u11_t x);
    return {5'b0, y, 5'b0, x};
  endfunction
endpackage

// File: rtl/u8layer_seq_if.sv
// u8layer_seq_if: parameter-write / kick / run link between the sequencer and the address generator
interface u8layer_seq_if;
  import u8layer_seq_pkg::*;
  logic pwe;
  u8_t padr;
  u32_t pdata;
  logic kick;
  logic run;
  modport master (output pwe, padr, pdata, kick, input run);
  modport slave (input pwe, padr, pdata, kick, output run);
endinterface

// File: rtl/u8layer_seq_dsc_ram.sv
// u8dsc_ram: 1W/1R synchronous descriptor RAM, one-cycle read latency, no reset
module u8dsc_ram
  import u8layer_seq_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  u32_t          wd,
  input  logic [AW-1:0] ra,
  output u32_t          rd
);
  u32_t mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end
endmodule

// File: rtl/u8layer_seq.sv
// u8layer_seq: streams per-layer generator params and lane start positions, then kicks and waits for the frame
module u8layer_seq
  import u8layer_seq_pkg::*;
#(
  parameter int Np = 1,
  parameter int MAXL = 16,
  parameter int TOUT = 2**20,
  localparam int AW = $clog2(MAXL * DSC_STRIDE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dsc_we,
  input  logic [AW-1:0] dsc_adr,
  input  u32_t          dsc_wdata,
  input  logic          start,
  input  u8_t           n_layer,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          err,
  output u8_t           layer_idx,
  u8layer_seq_if.master gen
);
  localparam int TW = $clog2(TOUT + 1);
  localparam int LW = 7;
  state_t state, state_d;
  logic [4:0] k, rd_k;
  logic rd_v;
  logic [LW-1:0] lane;
  logic [20:0] x;
  u11_t y, outw;
  u20_t ph;
  u8_t nl;
  logic [TW-1:0] tcnt;
  u32_t rdata;
  logic norm, tout, run;
  assign run = gen.run;
  assign norm = outw != '0 && x >= {10'b0, outw};
  assign tout = tcnt == TW'(TOUT - 1);
  u8dsc_ram #(.DEPTH(MAXL * DSC_STRIDE), .AW(AW)) u_ram (
    .clk(clk), .we(dsc_we), .wa(dsc_adr), .wd(dsc_wdata),
    .ra(AW'({layer_idx, k})), .rd(rdata)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:      if (start) state_d = n_layer == '0 ? S_DONE : S_FETCH;
      S_FETCH:     if (k == 5'(ADRGEN_NPARAM)) state_d = S_LANE;
      S_LANE:      state_d = lane == '0 ? S_LWR : S_NORM;
      S_NORM:      if (!norm) state_d = S_LWR;
      S_LWR:       state_d = lane == LW'(Np - 1) ? S_KICK : S_LANE;
      S_KICK:      state_d = S_WAIT_RUN;
      S_WAIT_RUN:  state_d = run ? S_WAIT_DONE : tout ? S_DONE : S_WAIT_RUN;
      S_WAIT_DONE: state_d = !run ? S_NEXT : tout ? S_DONE : S_WAIT_DONE;
      S_NEXT:      state_d = (layer_idx + 1'b1 == nl || abort) ? S_DONE : S_FETCH;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      k <= '0;
      rd_k <= '0;
      rd_v <= 1'b0;
      lane <= '0;
      x <= '0;
      y <= '0;
      outw <= '0;
      ph <= '0;
      nl <= '0;
      tcnt <= '0;
      layer_idx <= '0;
      err <= 1'b0;
      busy <= 1'b0;
    end else begin
      rd_v <= state == S_FETCH && k < 5'(ADRGEN_NPARAM);
      rd_k <= k;
      busy <= state_d != S_IDLE && state_d != S_DONE;
      tcnt <= state_d != state ? '0 : tcnt + 1'b1;
      if (rd_v && rd_k == 5'd7) outw <= rdata[10:0];
      if (rd_v && rd_k == 5'd9) ph <= rdata[19:0];
      if (state == S_IDLE || state == S_NEXT) k <= '0;
      else if (state == S_FETCH && k != 5'(ADRGEN_NPARAM)) k <= k + 1'b1;
      if (state == S_IDLE && start) nl <= n_layer;
      if (state == S_IDLE && start) layer_idx <= '0;
      else if (state == S_NEXT && state_d == S_FETCH) layer_idx <= layer_idx + 1'b1;
      err <= (state == S_IDLE && start) ? 1'b0
           : err | (tout && ((state == S_WAIT_RUN && !run) || (state == S_WAIT_DONE && run)));
      if (state == S_FETCH) begin
        lane <= '0;
        x <= '0;
        y <= '0;
      end else if (state == S_LANE && lane != '0) x <= x + {1'b0, ph};
      else if (state == S_NORM && norm) begin
        x <= x - {10'b0, outw};
        y <= y + 1'b1;
      end else if (state == S_LWR) lane <= lane + 1'b1;
    end
  // lane writes take priority over the param stream; the two never overlap
  always_comb begin
    gen.pwe = rd_v || state == S_LWR;
    gen.kick = state == S_KICK;
    done = state == S_DONE;
    gen.padr = state == S_LWR ? 8'(ADRGEN_LANE_BASE) + {1'b0, lane} : rd_v ? {3'b0, rd_k} : '0;
    gen.pdata = state == S_LWR ? lane_word(y, x[10:0]) : rd_v ? rdata : '0;
  end
endmodule

// File: tb/tb_u8layer_seq.sv
// tb_u8layer_seq: directed self-checking bench with a behavioural generator model
module tb_u8layer_seq;
  import u8layer_seq_pkg::*;
  localparam int NP = 4, MAXL = 16, TOUT = 64, AW = $clog2(MAXL * 32);
  logic clk = 0, rst = 1, dsc_we = 0, start = 0, abort = 0;
  logic [AW-1:0] dsc_adr = '0;
  u32_t dsc_wdata = '0;
  u8_t n_layer = '0;
  logic busy, done, err;
  u8_t layer_idx;
  u8layer_seq_if gif();
  u8layer_seq #(.Np(NP), .MAXL(MAXL), .TOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .dsc_we(dsc_we), .dsc_adr(dsc_adr), .dsc_wdata(dsc_wdata),
    .start(start), .n_layer(n_layer), .abort(abort), .busy(busy), .done(done),
    .err(err), .layer_idx(layer_idx), .gen(gif)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  int kicks = 0, dones = 0, bad_pwe = 0;
  logic [7:0] wa_q[$];
  u32_t wd_q[$];
  u8_t kl_q[$];
  bit gen_on = 1;
  logic [5:0] gcnt;
  int outw_t[3] = '{5, 3, 10};
  int ph_t[3] = '{7, 4, 25};
  always @(posedge clk or posedge rst)
    if (rst) gcnt <= '0;
    else if (gif.kick && gen_on) gcnt <= 6'd1;
    else if (gcnt == 6'd42) gcnt <= '0;
    else if (gcnt != '0) gcnt <= gcnt + 6'd1;
  assign gif.run = gcnt >= 6'd3;
  always @(negedge clk)
    if (!rst) begin
      if (gif.pwe) begin
        wa_q.push_back(gif.padr);
        wd_q.push_back(gif.pdata);
        if (gif.run || gif.kick) bad_pwe++;
      end
      if (gif.kick) begin
        kicks++;
        kl_q.push_back(layer_idx);
      end
      if (done) dones++;
    end
  function automatic u32_t dsc_word(input int l, input int k);
    if (k == 7) return u32_t'(outw_t[l]);
    if (k == 9) return u32_t'(ph_t[l]);
    return {8'(l + 1), 8'(k), 16'hA5C3};
  endfunction
  function automatic u32_t exp_lane(input int l, input int i);
    int p = i * ph_t[l];
    return {5'b0, 11'(p / outw_t[l]), 5'b0, 11'(p % outw_t[l])};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic go(input int n);
    @(negedge clk);
    start = 1;
    n_layer = 8'(n);
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done(input int lim);
    int c = 0;
    while (done !== 1'b1 && c < lim) begin
      @(negedge clk);
      c++;
    end
    chk("done_seen", {31'b0, done}, 1);
  endtask
  task automatic chk_burst(input int b, input int l);
    if (wa_q.size() < b + 23 + NP) begin
      chk("burst_len", wa_q.size(), b + 23 + NP);
      return;
    end
    for (int j = 0; j < 23; j++) begin
      chk($sformatf("padr_l%0d_w%0d", l, j), wa_q[b + j], j);
      chk($sformatf("pdata_l%0d_w%0d", l, j), wd_q[b + j], dsc_word(l, j));
    end
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("lane_adr_l%0d_%0d", l, i), wa_q[b + 23 + i], 24 + i);
      chk($sformatf("lane_dat_l%0d_%0d", l, i), wd_q[b + 23 + i], exp_lane(l, i));
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_done"}, {31'b0, done}, 0);
    chk({tag, "_err"}, {31'b0, err}, 0);
    chk({tag, "_pwe"}, {31'b0, gif.pwe}, 0);
    chk({tag, "_kick"}, {31'b0, gif.kick}, 0);
    chk({tag, "_padr"}, {24'b0, gif.padr}, 0);
    chk({tag, "_pdata"}, gif.pdata, 0);
    chk({tag, "_lidx"}, {24'b0, layer_idx}, 0);
  endtask
  initial begin
    int b, kb, db, c;
    @(negedge clk);
    chk_idle_outputs("reset");
    rst = 0;
    for (int l = 0; l < 3; l++)
      for (int k = 0; k < 32; k++) begin
        @(negedge clk);
        dsc_we = 1;
        dsc_adr = AW'(l * 32 + k);
        dsc_wdata = dsc_word(l, k);
      end
    @(negedge clk);
    dsc_we = 0;
    // single layer, hand-computed lane positions for outW=5, pH=7
    b = wa_q.size(); kb = kicks; db = dones;
    go(1);
    chk("t1_busy", {31'b0, busy}, 1);
    wait_done(400);
    chk("t1_err", {31'b0, err}, 0);
    @(negedge clk);
    chk("t1_done_1cyc", {31'b0, done}, 0);
    chk("t1_busy_end", {31'b0, busy}, 0);
    chk("t1_nwr", wa_q.size() - b, 27);
    chk_burst(b, 0);
    if (wd_q.size() >= b + 27) begin
      chk("t1_lane0", wd_q[b + 23], 32'h0000_0000);
      chk("t1_lane1", wd_q[b + 24], 32'h0001_0002);
      chk("t1_lane2", wd_q[b + 25], 32'h0002_0004);
      chk("t1_lane3", wd_q[b + 26], 32'h0004_0001);
    end
    chk("t1_kicks", kicks - kb, 1);
    chk("t1_dones", dones - db, 1);
    // three layers
    b = wa_q.size(); kb = kicks;
    go(3);
    wait_done(1500);
    @(negedge clk);
    chk("t2_nwr", wa_q.size() - b, 81);
    chk_burst(b, 0);
    chk_burst(b + 27, 1);
    chk_burst(b + 54, 2);
    chk("t2_kicks", kicks - kb, 3);
    if (kl_q.size() >= kb + 3)
      for (int i = 0; i < 3; i++) chk($sformatf("t2_kick_layer%0d", i), {24'b0, kl_q[kb + i]}, i);
    chk("t2_bad_pwe", bad_pwe, 0);
    chk("t2_err", {31'b0, err}, 0);
    // abort during layer 1 frame
    b = wa_q.size(); kb = kicks;
    go(3);
    c = 0;
    while (kicks < kb + 2 && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk("t3_second_kick", kicks - kb, 2);
    abort = 1;
    wait_done(300);
    abort = 0;
    @(negedge clk);
    chk("t3_kicks", kicks - kb, 2);
    chk("t3_nwr", wa_q.size() - b, 54);
    chk("t3_busy", {31'b0, busy}, 0);
    chk("t3_err", {31'b0, err}, 0);
    // generator never runs: timeout
    gen_on = 0;
    go(1);
    c = 0;
    while (gif.kick !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("t4_kick", {31'b0, gif.kick}, 1);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (done !== 1'b1 && c < 200);
    chk("t4_latency", c, 65);
    chk("t4_err", {31'b0, err}, 1);
    @(negedge clk);
    chk("t4_done_1cyc", {31'b0, done}, 0);
    chk("t4_busy", {31'b0, busy}, 0);
    chk("t4_err_sticky", {31'b0, err}, 1);
    gen_on = 1;
    // zero layers, then start while busy
    b = wa_q.size(); kb = kicks; db = dones;
    go(0);
    chk("t5_done_next", {31'b0, done}, 1);
    chk("t5_err_clr", {31'b0, err}, 0);
    @(negedge clk);
    chk("t5_done_1cyc", {31'b0, done}, 0);
    chk("t5_no_pwe", wa_q.size() - b, 0);
    go(1);
    repeat (3) @(negedge clk);
    go(1);
    wait_done(400);
    @(negedge clk);
    chk("t5_kicks", kicks - kb, 1);
    chk("t5_nwr", wa_q.size() - b, 27);
    chk("t5_dones", dones - db, 2);
    // async reset during the NORM loop of lane 1
    go(1);
    c = 0;
    while (!(gif.pwe === 1'b1 && gif.padr == 8'd24) && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("t6_lane0_seen", {24'b0, gif.padr}, 24);
    repeat (2) @(negedge clk);
    chk("t6_busy_pre", {31'b0, busy}, 1);
    #1 rst = 1;
    #1 chk_idle_outputs("t6_rst");
    #1 rst = 0;
    b = wa_q.size(); kb = kicks;
    go(1);
    wait_done(400);
    @(negedge clk);
    chk("t6_nwr", wa_q.size() - b, 27);
    chk_burst(b, 0);
    chk("t6_kicks", kicks - kb, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
